// File: rtl/vga_fb_pkg.sv
// Shared types and default geometry for the VGA framebuffer access path.
package vga_fb_pkg;

    localparam int unsigned H_RES  = 480;
    localparam int unsigned V_RES  = 360;
    localparam int unsigned NPIX   = H_RES * V_RES;
    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 3;

    typedef enum logic {
        IDLE,
        CLEAR
    } fb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wq_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port framebuffer arbiter: display fetch owns the port while visible,
// queued serial writes or a hardware screen clear use the blanking cycles.
module fb_access_arbiter #(
    parameter int unsigned H_RES    = vga_fb_pkg::H_RES,
    parameter int unsigned V_RES    = vga_fb_pkg::V_RES,
    parameter int unsigned ADDR_W   = vga_fb_pkg::ADDR_W,
    parameter int unsigned DATA_W   = vga_fb_pkg::DATA_W,
    parameter int unsigned WQ_DEPTH = 4
) (
    input  logic              clk_vga,
    input  logic              rst,
    input  logic              visible,
    input  logic              vs,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              wr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pixel,
    output logic              pixel_valid
);

    import vga_fb_pkg::*;

    localparam int unsigned       NPIX_L   = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX_L - 1);

    fb_state_t         state;
    fb_state_t         state_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_color_q;
    wq_entry_t         wq_in;
    wq_entry_t         wq_head;
    logic              wq_full;
    logic              wq_empty;
    logic              wq_push;
    logic              wq_pop;
    logic              wr_fire;
    logic              wr_in_range;

    assign wr_ready    = !wq_full;
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = (wr_addr < ADDR_W'(NPIX_L));
    assign wq_push     = wr_fire && wr_in_range;
    assign wq_in       = '{addr: wr_addr, data: wr_data};
    assign clr_busy    = (state == CLEAR);
    assign pixel       = pixel_valid ? mem_rdata : '0;

    sync_fifo #(
        .WIDTH ($bits(wq_entry_t)),
        .DEPTH (WQ_DEPTH)
    ) u_wq (
        .clk   (clk_vga),
        .rst   (rst),
        .push  (wq_push),
        .wdata (wq_in),
        .pop   (wq_pop),
        .rdata (wq_head),
        .full  (wq_full),
        .empty (wq_empty)
    );

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A clear request wins over a pending pop so queued pixels land after the clear.
    always_comb begin
        state_nxt = state;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        wq_pop    = 1'b0;
        if (visible) begin
            mem_addr = rd_addr;
        end
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                end else if (!visible && !wq_empty) begin
                    mem_we    = 1'b1;
                    mem_addr  = wq_head.addr;
                    mem_wdata = wq_head.data;
                    wq_pop    = 1'b1;
                end
            end
            CLEAR: begin
                if (!visible) begin
                    mem_we    = 1'b1;
                    mem_addr  = clr_addr;
                    mem_wdata = clr_color_q;
                    if (clr_addr == LAST_PIX) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            rd_addr     <= '0;
            clr_addr    <= '0;
            clr_color_q <= '0;
            wr_err      <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_valid <= visible;
            if (wr_fire && !wr_in_range) begin
                wr_err <= 1'b1;
            end
            if (!vs) begin
                rd_addr <= '0;
            end else if (visible) begin
                rd_addr <= (rd_addr == LAST_PIX) ? '0 : rd_addr + ADDR_W'(1);
            end
            if (state == IDLE && clr_req) begin
                clr_addr    <= '0;
                clr_color_q <= clr_color;
            end else if (state == CLEAR && !visible) begin
                clr_addr <= clr_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter on a reduced 48x36 geometry with a RAM model.
module tb_fb_access_arbiter;

    localparam int unsigned TB_H    = 48;
    localparam int unsigned TB_V    = 36;
    localparam int unsigned TB_NPIX = TB_H * TB_V;
    localparam int          NVEC    = 23;

    logic        clk_vga;
    logic        rst;
    logic        visible;
    logic        vs;
    logic        wr_valid;
    logic        wr_ready;
    logic [17:0] wr_addr;
    logic [2:0]  wr_data;
    logic        clr_req;
    logic [2:0]  clr_color;
    logic        clr_busy;
    logic        wr_err;
    logic [17:0] mem_addr;
    logic        mem_we;
    logic [2:0]  mem_wdata;
    logic [2:0]  mem_rdata;
    logic [2:0]  pixel;
    logic        pixel_valid;

    logic [2:0]  ram [2048];

    int total;
    int bad;

    typedef struct {
        logic        vis;
        logic        vsn;
        logic        wv;
        logic [17:0] wa;
        logic [2:0]  wd;
        logic        e_we;
        logic [17:0] e_addr;
        logic [2:0]  e_wd;
        logic        e_rdy;
        logic        e_err;
    } vec_t;

    vec_t vecs [NVEC];

    fb_access_arbiter #(
        .H_RES    (TB_H),
        .V_RES    (TB_V),
        .ADDR_W   (18),
        .DATA_W   (3),
        .WQ_DEPTH (4)
    ) dut (
        .clk_vga     (clk_vga),
        .rst         (rst),
        .visible     (visible),
        .vs          (vs),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clr_req     (clr_req),
        .clr_color   (clr_color),
        .clr_busy    (clr_busy),
        .wr_err      (wr_err),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .pixel       (pixel),
        .pixel_valid (pixel_valid)
    );

    initial clk_vga = 1'b0;
    always #5 clk_vga = ~clk_vga;

    // Synchronous RAM with one-cycle read latency.
    always @(posedge clk_vga) begin
        if (mem_we && mem_addr < 18'(TB_NPIX)) begin
            ram[mem_addr[10:0]] <= mem_wdata;
        end
        mem_rdata <= (mem_addr < 18'(TB_NPIX)) ? ram[mem_addr[10:0]] : 3'd0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic tick();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic chk_port(input string name, input logic we, input logic [17:0] addr,
                            input logic [2:0] data);
        chk({name, "_we"}, 32'(mem_we), 32'(we));
        chk({name, "_addr"}, 32'(mem_addr), 32'(addr));
        chk({name, "_wdata"}, 32'(mem_wdata), 32'(data));
    endtask

    initial begin
        int exp_ca;
        int cyc;
        logic [2:0] exp_px;

        total = 0;
        bad   = 0;
        rst = 1'b1; visible = 1'b1; vs = 1'b1; wr_valid = 1'b0;
        wr_addr = '0; wr_data = '0; clr_req = 1'b0; clr_color = '0;

        //            vis   vs    wv    wa          wd    we    addr        wd    rdy   err
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 18'd0,    3'd0, 1'b0, 18'd0,    3'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 18'd1000, 3'd5, 1'b0, 18'd1,    3'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 18'd0,    3'd0, 1'b0, 18'd2,    3'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 18'd0,    3'd0, 1'b1, 18'd1000, 3'd5, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 18'd0,    3'd0, 1'b0, 18'd0,    3'd0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 18'd0,    3'd0, 1'b0, 18'd3,    3'd0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 18'd0,    3'd0, 1'b0, 18'd0,    3'd0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 18'd0,    3'd0, 1'b0, 18'd0,    3'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 18'd1727, 3'd7, 1'b0, 18'd1,    3'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 18'd1728, 3'd3, 1'b1, 18'd1727, 3'd7, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 18'd0,    3'd0, 1'b0, 18'd0,    3'd0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 18'd0,    3'd0, 1'b0, 18'd2,    3'd0, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 18'd10,   3'd1, 1'b0, 18'd3,    3'd0, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 18'd11,   3'd2, 1'b0, 18'd4,    3'd0, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 18'd12,   3'd3, 1'b0, 18'd5,    3'd0, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 18'd13,   3'd4, 1'b0, 18'd6,    3'd0, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 18'd14,   3'd5, 1'b0, 18'd7,    3'd0, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 18'd14,   3'd5, 1'b1, 18'd10,   3'd1, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 18'd14,   3'd5, 1'b1, 18'd11,   3'd2, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 18'd0,    3'd0, 1'b1, 18'd12,   3'd3, 1'b1, 1'b1};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 18'd0,    3'd0, 1'b1, 18'd13,   3'd4, 1'b1, 1'b1};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 18'd0,    3'd0, 1'b1, 18'd14,   3'd5, 1'b1, 1'b1};
        vecs[22] = '{1'b0, 1'b1, 1'b0, 18'd0,    3'd0, 1'b0, 18'd0,    3'd0, 1'b1, 1'b1};

        // Outputs while reset is held, with visible high.
        settle();
        chk_port("reset", 1'b0, 18'd0, 3'd0);
        chk("reset_pixel", 32'(pixel), 32'd0);
        chk("reset_pixel_valid", 32'(pixel_valid), 32'd0);
        chk("reset_clr_busy", 32'(clr_busy), 32'd0);
        chk("reset_wr_err", 32'(wr_err), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            visible  = vecs[i].vis;
            vs       = vecs[i].vsn;
            wr_valid = vecs[i].wv;
            wr_addr  = vecs[i].wa;
            wr_data  = vecs[i].wd;
            settle();
            chk_port($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_addr, vecs[i].e_wd);
            chk($sformatf("vec%0d_ready", i), 32'(wr_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_err", i), 32'(wr_err), 32'(vecs[i].e_err));
            tick();
        end
        wr_valid = 1'b0;

        // One full frame of fetch addresses, then wrap and vs clear.
        vs = 1'b0; visible = 1'b0;
        tick();
        vs = 1'b1;
        for (int ln = 0; ln < int'(TB_V); ln++) begin
            for (int x = 0; x < int'(TB_H); x++) begin
                visible = 1'b1;
                settle();
                chk("frame_addr", 32'(mem_addr), 32'(ln * int'(TB_H) + x));
                chk("frame_we", 32'(mem_we), 32'd0);
                tick();
            end
            for (int b = 0; b < 4; b++) begin
                visible = 1'b0;
                settle();
                chk("frame_blank_we", 32'(mem_we), 32'd0);
                tick();
            end
        end
        visible = 1'b1;
        settle();
        chk("wrap_addr0", 32'(mem_addr), 32'd0);
        tick();
        settle();
        chk("wrap_addr1", 32'(mem_addr), 32'd1);
        tick();
        visible = 1'b0; vs = 1'b0;
        tick();
        vs = 1'b1; visible = 1'b1;
        settle();
        chk("vs_clear_addr", 32'(mem_addr), 32'd0);
        tick();

        // Queue a pixel, then request a clear while it is still pending.
        wr_valid = 1'b1; wr_addr = 18'd77; wr_data = 3'd6;
        settle();
        chk("pre_clr_push_ready", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0; visible = 1'b0; clr_req = 1'b1; clr_color = 3'd2;
        settle();
        chk("clr_req_holds_queue_we", 32'(mem_we), 32'd0);
        chk("clr_req_busy", 32'(clr_busy), 32'd0);
        tick();
        clr_req = 1'b0;

        exp_ca = 0;
        cyc = 0;
        while (exp_ca < int'(TB_NPIX) && cyc < 4 * int'(TB_NPIX)) begin
            visible   = (cyc % 4 == 3);
            clr_req   = (cyc == 100);
            clr_color = (cyc == 100) ? 3'd5 : 3'd2;
            wr_valid  = (cyc == 101);
            wr_addr   = 18'd88;
            wr_data   = 3'd4;
            settle();
            chk("clr_busy", 32'(clr_busy), 32'd1);
            if (cyc == 101) begin
                chk("clr_midpush_ready", 32'(wr_ready), 32'd1);
            end
            if (visible) begin
                chk("clr_visible_we", 32'(mem_we), 32'd0);
            end else begin
                chk_port("clr_write", 1'b1, 18'(exp_ca), 3'd2);
                exp_ca++;
            end
            tick();
            cyc++;
        end
        clr_req = 1'b0; wr_valid = 1'b0; visible = 1'b0;
        settle();
        chk("clr_done_busy", 32'(clr_busy), 32'd0);
        chk_port("post_clr_q0", 1'b1, 18'd77, 3'd6);
        tick();
        settle();
        chk_port("post_clr_q1", 1'b1, 18'd88, 3'd4);
        tick();
        settle();
        chk_port("post_clr_idle", 1'b0, 18'd0, 3'd0);
        tick();

        // Scan out the first 100 pixels through the RAM model.
        vs = 1'b0;
        tick();
        vs = 1'b1;
        for (int k = 0; k < 102; k++) begin
            visible = (k < 100);
            settle();
            if (k == 0 || k == 101) begin
                chk("scan_pv_low", 32'(pixel_valid), 32'd0);
                chk("scan_pixel_gated", 32'(pixel), 32'd0);
            end else begin
                exp_px = (k - 1 == 77) ? 3'd6 : ((k - 1 == 88) ? 3'd4 : 3'd2);
                chk("scan_pv", 32'(pixel_valid), 32'd1);
                chk($sformatf("scan_pixel%0d", k - 1), 32'(pixel), 32'(exp_px));
            end
            tick();
        end

        // Reset in the middle of a clear.
        visible = 1'b0; clr_req = 1'b1; clr_color = 3'd3;
        settle();
        tick();
        clr_req = 1'b0;
        exp_ca = 0;
        while (exp_ca < 500) begin
            settle();
            chk_port("clr2_write", 1'b1, 18'(exp_ca), 3'd3);
            exp_ca++;
            tick();
        end
        rst = 1'b1;
        settle();
        chk_port("midclr_rst", 1'b0, 18'd0, 3'd0);
        chk("midclr_rst_busy", 32'(clr_busy), 32'd0);
        chk("midclr_rst_err", 32'(wr_err), 32'd0);
        chk("midclr_rst_ready", 32'(wr_ready), 32'd1);
        chk("midclr_rst_pv", 32'(pixel_valid), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("after_rst_we", 32'(mem_we), 32'd0);
            chk("after_rst_busy", 32'(clr_busy), 32'd0);
            tick();
        end

        // Full-resolution out-of-range address is dropped and flagged.
        wr_valid = 1'b1; wr_addr = 18'd172800; wr_data = 3'd1;
        settle();
        chk("oor_ready", 32'(wr_ready), 32'd1);
        chk("oor_err_before", 32'(wr_err), 32'd0);
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("oor_no_write", 32'(mem_we), 32'd0);
            chk("oor_err_sticky", 32'(wr_err), 32'd1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
